// File: rtl/add_acc_seq.sv
// add_acc_seq: handshaked block add-accumulator.
// Each accepted beat adds a+b into a BWOP-bit accumulator. After `len` beats the block
// total is presented on a registered valid/ready output, together with a sticky overflow flag.
// Optional build macro ADD_ACC_SAT_EN: the accumulator saturates at 2^BWOP-1 on overflow
// instead of wrapping modulo 2^BWOP.
module add_acc_seq #(
  parameter int unsigned BWOP = 32,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BWOP-1:0] a,
  input  logic [BWOP-1:0] b,
  input  logic [CNTW-1:0] len,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BWOP-1:0] c,
  output logic            ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e          state;
  logic [BWOP-1:0] acc;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] len_q;
  logic            ovf_run;  // overflow seen so far in the block being accumulated

  logic            accept;
  logic            first_beat;
  logic [BWOP+1:0] sum;
  logic            ovf_evt;
  logic [BWOP-1:0] acc_nxt;
  logic            blk_ovf;
  logic [CNTW-1:0] len_eff;
  logic            blk_done;

  // Handshake, three-term sum, overflow detection and block-completion decode
  always_comb begin
    // HOLD only takes a beat when the held result retires on the same edge
    in_ready   = !rst && ((state != StHold) || out_ready);
    accept     = in_valid && in_ready;
    // Any beat accepted outside ACC opens a new block
    first_beat = (state != StAcc);
    sum        = (first_beat ? {(BWOP+2){1'b0}} : {2'b00, acc}) + {2'b00, a} + {2'b00, b};
    ovf_evt    = |sum[BWOP+1:BWOP];
`ifdef ADD_ACC_SAT_EN
    // Once clamped, the sum keeps overflowing or stays at max, so it stays clamped
    acc_nxt    = ovf_evt ? {BWOP{1'b1}} : sum[BWOP-1:0];
`else
    acc_nxt    = sum[BWOP-1:0];
`endif
    blk_ovf    = ovf_evt || (!first_beat && ovf_run);
    len_eff    = (len == '0) ? CNTW'(1) : len;
    blk_done   = first_beat ? (len_eff == CNTW'(1)) : ((cnt + CNTW'(1)) == len_q);
  end

  // Block FSM with registered result, valid and overflow outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      ovf_run   <= 1'b0;
      c         <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      acc     <= acc_nxt;
      ovf_run <= blk_ovf;
      if (first_beat) begin
        cnt   <= CNTW'(1);
        len_q <= len_eff;
      end else begin
        cnt   <= cnt + CNTW'(1);
      end
      if (blk_done) begin
        state     <= StHold;
        out_valid <= 1'b1;
        c         <= acc_nxt;
        ovf       <= blk_ovf;
      end else begin
        // Also retires a held result when a new multi-beat block starts from HOLD
        state     <= StAcc;
        out_valid <= 1'b0;
      end
    end else if (state == StHold && out_ready) begin
      state     <= StIdle;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_acc_seq.sv
// tb_add_acc_seq: directed self-checking bench for add_acc_seq.
// Two instances share stimulus: a 32-bit one and an 8-bit one for overflow cases.
module tb_add_acc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  len;

  logic        in_ready32, out_valid32, ovf32;
  logic [31:0] c32;
  logic        in_ready8, out_valid8, ovf8;
  logic [7:0]  c8;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ADD_ACC_SAT_EN
  localparam logic [7:0] ExpOvf8 = 8'd255;
`else
  localparam logic [7:0] ExpOvf8 = 8'd94;
`endif

  always #5 clk = ~clk;

  add_acc_seq #(.BWOP(32), .CNTW(8)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .a         (a),
    .b         (b),
    .len       (len),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .c         (c32),
    .ovf       (ovf32)
  );

  add_acc_seq #(.BWOP(8), .CNTW(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .a         (a[7:0]),
    .b         (b[7:0]),
    .len       (len),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .c         (c8),
    .ovf       (ovf8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic [7:0] lv);
    in_valid = v;
    a        = av;
    b        = bv;
    len      = lv;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 0, 0, 0);
    tick();
    n_checks++;
    if (in_ready32 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready32);
    end
    tick();
    n_checks++;
    if (out_valid32 !== 1'b0 || c32 !== 32'd0 || ovf32 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b c=%0d ovf=%b expected v=0 c=0 ovf=0",
               out_valid32, c32, ovf32);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got rdy=%b v=%b expected rdy=1 v=0",
               in_ready32, out_valid32);
    end
  endtask

  task automatic test_basic();
    logic [31:0] av [4] = '{32'd1, 32'd3, 32'd5, 32'd7};
    logic [31:0] bv [4] = '{32'd2, 32'd4, 32'd6, 32'd8};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, av[i], bv[i], (i == 0) ? 8'd4 : 8'd9);  // len ignored after first beat
      tick();
      if (i == 2) begin
        n_checks++;
        if (out_valid32 !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_early_valid: got %b expected 0", out_valid32);
        end
      end
    end
    drive(1'b0, 0, 0, 0);
    n_checks++;
    if (out_valid32 !== 1'b1 || c32 !== 32'd36 || ovf32 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got v=%b c=%0d ovf=%b expected v=1 c=36 ovf=0",
               out_valid32, c32, ovf32);
    end
    tick();
    n_checks++;
    if (out_valid32 !== 1'b0 || c32 !== 32'd36) begin
      n_fail++;
      $display("FAIL basic_retire: got v=%b c=%0d expected v=0 c=36", out_valid32, c32);
    end
  endtask

  task automatic test_len01();
    logic [7:0] lens [2] = '{8'd0, 8'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'd10, 32'd20, lens[i]);
      tick();
      drive(1'b0, 0, 0, 0);
      n_checks++;
      if (out_valid32 !== 1'b1 || c32 !== 32'd30) begin
        n_fail++;
        $display("FAIL len%0d_result: got v=%b c=%0d expected v=1 c=30",
                 lens[i], out_valid32, c32);
      end
      tick();
      n_checks++;
      if (out_valid32 !== 1'b0) begin
        n_fail++;
        $display("FAIL len%0d_retire: got v=%b expected 0", lens[i], out_valid32);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'd5, 32'd5, 8'd2);
    tick();
    drive(1'b1, 32'd6, 32'd6, 8'd7);
    tick();
    // Next block's single beat waits on the input while the result is held
    drive(1'b1, 32'd1, 32'd2, 8'd1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid32 !== 1'b1 || c32 !== 32'd22 || in_ready32 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b c=%0d rdy=%b expected v=1 c=22 rdy=0",
                 i, out_valid32, c32, in_ready32);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_follow: got %b expected 1", in_ready32);
    end
    tick();
    drive(1'b0, 0, 0, 0);
    n_checks++;
    if (out_valid32 !== 1'b1 || c32 !== 32'd3) begin
      n_fail++;
      $display("FAIL bp_same_edge: got v=%b c=%0d expected v=1 c=3", out_valid32, c32);
    end
    tick();
    n_checks++;
    if (out_valid32 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_retire: got v=%b expected 0", out_valid32);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 32'd1, 32'd1, 8'd2);
    tick();
    drive(1'b1, 32'd2, 32'd2, 8'd2);
    tick();
    n_checks++;
    if (out_valid32 !== 1'b1 || c32 !== 32'd6) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b c=%0d expected v=1 c=6", out_valid32, c32);
    end
    drive(1'b1, 32'd3, 32'd3, 8'd2);
    #1;
    n_checks++;
    if (in_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b expected 1", in_ready32);
    end
    tick();
    drive(1'b1, 32'd4, 32'd4, 8'd5);
    n_checks++;
    if (out_valid32 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got v=%b expected 0", out_valid32);
    end
    tick();
    drive(1'b0, 0, 0, 0);
    n_checks++;
    if (out_valid32 !== 1'b1 || c32 !== 32'd14) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b c=%0d expected v=1 c=14", out_valid32, c32);
    end
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    drive(1'b1, 32'd200, 32'd100, 8'd2);
    tick();
    drive(1'b1, 32'd50, 32'd0, 8'd2);
    tick();
    drive(1'b0, 0, 0, 0);
    n_checks++;
    if (out_valid8 !== 1'b1 || c8 !== ExpOvf8 || ovf8 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf8_result: got v=%b c=%0d ovf=%b expected v=1 c=%0d ovf=1",
               out_valid8, c8, ovf8, ExpOvf8);
    end
    n_checks++;
    if (c32 !== 32'd350 || ovf32 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf32_result: got c=%0d ovf=%b expected c=350 ovf=0", c32, ovf32);
    end
    tick();
    drive(1'b1, 32'd1, 32'd1, 8'd1);
    tick();
    drive(1'b0, 0, 0, 0);
    n_checks++;
    if (out_valid8 !== 1'b1 || c8 !== 8'd2 || ovf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf8_clear: got v=%b c=%0d ovf=%b expected v=1 c=2 ovf=0",
               out_valid8, c8, ovf8);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 32'd1, 32'd1, 8'd3);
    tick();
    drive(1'b1, 32'd2, 32'd2, 8'd3);
    tick();
    drive(1'b0, 0, 0, 0);
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready32 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ready: got %b expected 0", in_ready32);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_valid32 !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_rst_no_valid_%0d: got %b expected 0", i, out_valid32);
      end
      tick();
    end
    drive(1'b1, 32'd4, 32'd4, 8'd1);
    tick();
    drive(1'b0, 0, 0, 0);
    n_checks++;
    if (out_valid32 !== 1'b1 || c32 !== 32'd8) begin
      n_fail++;
      $display("FAIL mid_rst_next: got v=%b c=%0d expected v=1 c=8", out_valid32, c32);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len01();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
